rename_map_ckpt: RTL and testbench

Parametrised front-end register rename map with branch checkpointing. It renames up to RENAME_WIDTH instructions per cycle, with intra-group dependency bypass. It snapshots the speculative map at branches into a circular checkpoint buffer, so a single-cycle mispredict recovery does not have to wait for commit. It sits between decode and dispatch, beside the free list and the committed (back) map, and generalises the existing two-wide map with flush-only recovery.

---
 rtl/rename_map_ckpt_pkg.sv | 27 ++
 rtl/rename_map_ckpt_ckpt_buffer.sv | 65 ++++++
 rtl/rename_map_ckpt.sv | 71 +++++++
 tb/tb_rename_map_ckpt.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_map_ckpt_pkg.sv
// rename_map_ckpt_pkg: shared sizes, map/pointer types and the intra-group bypass lookup.
package rename_map_ckpt_pkg;
  localparam int ARCH_REGS    = 32;
  localparam int PHY_WIDTH    = 6;
  localparam int RENAME_WIDTH = 2;
  localparam int NUM_CKPT     = 4;
  localparam int CKPT_W       = $clog2(NUM_CKPT);
  localparam int AREG_W       = 5;
  typedef logic [PHY_WIDTH-1:0] phy_t;
  typedef phy_t [ARCH_REGS-1:0] map_t;
  typedef logic [CKPT_W:0] ckpt_ptr_t;
  // Youngest older effective slot writing the same arch reg overrides the map.
  function automatic phy_t bypass_lookup(
    input map_t                              m,
    input logic [AREG_W-1:0]                 arch,
    input int                                k,
    input logic [RENAME_WIDTH-1:0]           eff,
    input logic [AREG_W*RENAME_WIDTH-1:0]    rd_arch,
    input logic [PHY_WIDTH*RENAME_WIDTH-1:0] rd_new
  );
    phy_t r;
    r = m[arch];
    for (int j = 0; j < RENAME_WIDTH; j++)
      if (j < k && eff[j] && rd_arch[j*AREG_W +: AREG_W] == arch) r = rd_new[j*PHY_WIDTH +: PHY_WIDTH];
    return r;
  endfunction
endpackage

// File: rtl/rename_map_ckpt_ckpt_buffer.sv
// ckpt_buffer: circular map-snapshot store with valid bits, head/tail pointers and recovery truncation.
module ckpt_buffer
  import rename_map_ckpt_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              alloc,
  input  map_t              snap_map,
  input  logic              release_valid,
  input  logic [CKPT_W-1:0] release_id,
  input  logic              recover_valid,
  input  logic [CKPT_W-1:0] recover_id,
  output logic [CKPT_W-1:0] ckpt_id,
  output logic [CKPT_W:0]   ckpt_count,
  output logic              rec_ok,
  output map_t              rec_map
);
  ckpt_ptr_t head_q, head_d, tail_q, tail_d;
  logic [NUM_CKPT-1:0] valid_q, valid_d;
  map_t ram_q [NUM_CKPT];
  logic [CKPT_W-1:0] head_idx, rec_off, rel_off;
  logic rel_ok, adv;
  assign head_idx   = head_q[CKPT_W-1:0];
  assign ckpt_id    = tail_q[CKPT_W-1:0];
  assign ckpt_count = tail_q - head_q;
  assign rec_off    = recover_id - head_idx;
  assign rel_off    = release_id - head_idx;
  assign rec_ok     = !flush && recover_valid && {1'b0, rec_off} < ckpt_count;
  assign rel_ok     = release_valid && {1'b0, rel_off} < ckpt_count;
  assign adv        = head_q != tail_q && !valid_q[head_idx];
  assign rec_map    = ram_q[recover_id];
  // A recover onto the head entry empties the buffer, so head must not step past tail.
  always_comb begin
    valid_d = valid_q;
    tail_d  = tail_q;
    head_d  = (adv && !(rec_ok && rec_off == '0)) ? head_q + ckpt_ptr_t'(1) : head_q;
    if (rel_ok) valid_d[release_id] = 1'b0;
    if (rec_ok) begin
      tail_d = head_q + {1'b0, rec_off};
      for (int e = 0; e < NUM_CKPT; e++)
        if (CKPT_W'(e) - head_idx >= rec_off) valid_d[e] = 1'b0;
    end else if (alloc) begin
      valid_d[ckpt_id] = 1'b1;
      tail_d = tail_q + ckpt_ptr_t'(1);
    end
    if (flush) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
    end
  always_ff @(posedge clk)
    if (alloc) ram_q[ckpt_id] <= snap_map;
endmodule

// File: rtl/rename_map_ckpt.sv
// rename_map_ckpt: multi-slot register rename map with bypass and branch checkpoint recovery.
module rename_map_ckpt
  import rename_map_ckpt_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic [PHY_WIDTH*ARCH_REGS-1:0]    back_rat,
  input  logic [RENAME_WIDTH-1:0]           rn_valid,
  input  logic [RENAME_WIDTH-1:0]           rd_we,
  input  logic [AREG_W*RENAME_WIDTH-1:0]    rs1_arch,
  input  logic [AREG_W*RENAME_WIDTH-1:0]    rs2_arch,
  input  logic [AREG_W*RENAME_WIDTH-1:0]    rd_arch,
  input  logic [PHY_WIDTH*RENAME_WIDTH-1:0] rd_phy_new,
  input  logic [RENAME_WIDTH-1:0]           ckpt_req,
  output logic                              rn_ready,
  output logic [PHY_WIDTH*RENAME_WIDTH-1:0] rs1_phy,
  output logic [PHY_WIDTH*RENAME_WIDTH-1:0] rs2_phy,
  output logic [PHY_WIDTH*RENAME_WIDTH-1:0] rd_phy_old,
  output logic [CKPT_W-1:0]                 ckpt_id,
  input  logic                              ckpt_release_valid,
  input  logic [CKPT_W-1:0]                 ckpt_release_id,
  input  logic                              recover_valid,
  input  logic [CKPT_W-1:0]                 recover_id,
  output logic [CKPT_W:0]                   ckpt_count,
  output logic [PHY_WIDTH*ARCH_REGS-1:0]    map_out
);
  map_t map_q, map_d, map_new, snap_map, rec_map;
  logic [RENAME_WIDTH-1:0] eff;
  logic alloc_req, rec_ok;
  for (genvar k = 0; k < RENAME_WIDTH; k++) begin : g_slot
    assign eff[k] = rn_valid[k] && rd_we[k] && rd_arch[k*AREG_W +: AREG_W] != '0;
    assign rs1_phy[k*PHY_WIDTH +: PHY_WIDTH] =
      bypass_lookup(map_q, rs1_arch[k*AREG_W +: AREG_W], k, eff, rd_arch, rd_phy_new);
    assign rs2_phy[k*PHY_WIDTH +: PHY_WIDTH] =
      bypass_lookup(map_q, rs2_arch[k*AREG_W +: AREG_W], k, eff, rd_arch, rd_phy_new);
    assign rd_phy_old[k*PHY_WIDTH +: PHY_WIDTH] =
      bypass_lookup(map_q, rd_arch[k*AREG_W +: AREG_W], k, eff, rd_arch, rd_phy_new);
  end
  assign alloc_req = |(ckpt_req & rn_valid);
  assign rn_ready  = !flush && !recover_valid && !(alloc_req && ckpt_count == (CKPT_W+1)'(NUM_CKPT));
  assign map_out   = map_q;
  // The snapshot is taken right after the branch slot so younger slots stay out of it.
  always_comb begin
    map_new  = map_q;
    snap_map = map_q;
    for (int j = 0; j < RENAME_WIDTH; j++) begin
      if (eff[j]) map_new[rd_arch[j*AREG_W +: AREG_W]] = rd_phy_new[j*PHY_WIDTH +: PHY_WIDTH];
      if (ckpt_req[j] && rn_valid[j]) snap_map = map_new;
    end
  end
  assign map_d = flush ? map_t'(back_rat) : rec_ok ? rec_map : rn_ready ? map_new : map_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= phy_t'(i);
    else map_q <= map_d;
  ckpt_buffer u_ckpt (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .alloc        (rn_ready && alloc_req),
    .snap_map     (snap_map),
    .release_valid(ckpt_release_valid),
    .release_id   (ckpt_release_id),
    .recover_valid(recover_valid),
    .recover_id   (recover_id),
    .ckpt_id      (ckpt_id),
    .ckpt_count   (ckpt_count),
    .rec_ok       (rec_ok),
    .rec_map      (rec_map)
  );
endmodule

// File: tb/tb_rename_map_ckpt.sv
// tb_rename_map_ckpt: directed and randomized checks of rename_map_ckpt against an array-based model.
module tb_rename_map_ckpt;
  import rename_map_ckpt_pkg::*;
  localparam int N = NUM_CKPT;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush;
  logic [PHY_WIDTH*ARCH_REGS-1:0] back_rat;
  logic [RENAME_WIDTH-1:0] rn_valid, rd_we, ckpt_req;
  logic [AREG_W*RENAME_WIDTH-1:0] rs1_arch, rs2_arch, rd_arch;
  logic [PHY_WIDTH*RENAME_WIDTH-1:0] rd_phy_new, rs1_phy, rs2_phy, rd_phy_old;
  logic rn_ready, ckpt_release_valid, recover_valid;
  logic [CKPT_W-1:0] ckpt_id, ckpt_release_id, recover_id;
  logic [CKPT_W:0] ckpt_count;
  logic [PHY_WIDTH*ARCH_REGS-1:0] map_out, id_map, exp_map;
  int n_checks = 0;
  int n_pass = 0;
  int m_map[ARCH_REGS];
  int m_ck[N][ARCH_REGS];
  bit m_v[N];
  int m_head, m_tail;

  rename_map_ckpt dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .back_rat(back_rat),
    .rn_valid(rn_valid), .rd_we(rd_we), .rs1_arch(rs1_arch), .rs2_arch(rs2_arch),
    .rd_arch(rd_arch), .rd_phy_new(rd_phy_new), .ckpt_req(ckpt_req), .rn_ready(rn_ready),
    .rs1_phy(rs1_phy), .rs2_phy(rs2_phy), .rd_phy_old(rd_phy_old), .ckpt_id(ckpt_id),
    .ckpt_release_valid(ckpt_release_valid), .ckpt_release_id(ckpt_release_id),
    .recover_valid(recover_valid), .recover_id(recover_id),
    .ckpt_count(ckpt_count), .map_out(map_out)
  );

  always #5 clk = ~clk;

  function automatic bit slot_eff(int k);
    return rn_valid[k] && rd_we[k] && rd_arch[k*AREG_W +: AREG_W] != 0;
  endfunction

  function automatic int exp_lookup(int k, int arch);
    for (int j = k - 1; j >= 0; j--)
      if (slot_eff(j) && int'(rd_arch[j*AREG_W +: AREG_W]) == arch) return int'(rd_phy_new[j*PHY_WIDTH +: PHY_WIDTH]);
    return m_map[arch];
  endfunction

  function automatic int m_count();
    return m_tail - m_head;
  endfunction

  function automatic bit m_occ(int id);
    return ((id - m_head % N + N) % N) < m_count();
  endfunction

  function automatic bit m_ready();
    return !flush && !recover_valid && !((|(ckpt_req & rn_valid)) && m_count() == N);
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < ARCH_REGS; i++) m_map[i] = i;
    for (int i = 0; i < N; i++) m_v[i] = 0;
    m_head = 0;
    m_tail = 0;
  endfunction

  function automatic void m_step();
    bit vold[N];
    bit adv;
    int cnt, off;
    int nm[ARCH_REGS];
    vold = m_v;
    cnt = m_count();
    adv = m_head != m_tail && !vold[m_head % N];
    if (flush) begin
      for (int i = 0; i < ARCH_REGS; i++) m_map[i] = int'(back_rat[i*PHY_WIDTH +: PHY_WIDTH]);
      for (int i = 0; i < N; i++) m_v[i] = 0;
      m_head = 0;
      m_tail = 0;
      return;
    end
    if (ckpt_release_valid && m_occ(int'(ckpt_release_id))) m_v[ckpt_release_id] = 0;
    if (recover_valid && m_occ(int'(recover_id))) begin
      off = (int'(recover_id) - m_head % N + N) % N;
      m_map = m_ck[recover_id];
      for (int o = off; o < cnt; o++) m_v[(m_head + o) % N] = 0;
      m_tail = m_head + off;
    end else if (m_ready()) begin
      nm = m_map;
      for (int j = 0; j < RENAME_WIDTH; j++) begin
        if (slot_eff(j)) nm[rd_arch[j*AREG_W +: AREG_W]] = int'(rd_phy_new[j*PHY_WIDTH +: PHY_WIDTH]);
        if (ckpt_req[j] && rn_valid[j]) begin
          m_ck[m_tail % N] = nm;
          m_v[m_tail % N] = 1;
          m_tail++;
        end
      end
      m_map = nm;
    end
    if (adv && m_head != m_tail) m_head++;
  endfunction

  task automatic clear_inputs();
    flush = 0; rn_valid = '0; rd_we = '0; ckpt_req = '0;
    rs1_arch = '0; rs2_arch = '0; rd_arch = '0; rd_phy_new = '0;
    ckpt_release_valid = 0; ckpt_release_id = '0; recover_valid = 0; recover_id = '0;
  endtask

  task automatic set_slot(int k, int rs1, int rs2, int rd, int np, bit we, bit ck);
    rn_valid[k] = 1'b1;
    rd_we[k] = we;
    ckpt_req[k] = ck;
    rs1_arch[k*AREG_W +: AREG_W] = AREG_W'(rs1);
    rs2_arch[k*AREG_W +: AREG_W] = AREG_W'(rs2);
    rd_arch[k*AREG_W +: AREG_W] = AREG_W'(rd);
    rd_phy_new[k*PHY_WIDTH +: PHY_WIDTH] = PHY_WIDTH'(np);
  endtask

  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    #1;
  endtask

  task automatic alloc_four();
    for (int i = 0; i < N; i++) begin
      clear_inputs();
      set_slot(0, 0, 0, 0, 0, 0, 1);
      #1;
      n_checks++;
      if (ckpt_id !== CKPT_W'(i)) $display("FAIL alloc_id: got %0d expected %0d", ckpt_id, i); else n_pass++;
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    set_slot(0, 5, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (rs1_phy[5:0] !== 6'd5) $display("FAIL reset_rs1: got %0d expected 5", rs1_phy[5:0]); else n_pass++;
    n_checks++; if (ckpt_count !== '0) $display("FAIL reset_count: got %0d expected 0", ckpt_count); else n_pass++;
    n_checks++; if (rn_ready !== 1'b1) $display("FAIL reset_ready: got %0d expected 1", rn_ready); else n_pass++;
    n_checks++; if (map_out !== id_map) $display("FAIL reset_map: got %h expected %h", map_out, id_map); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_bypass();
    clear_inputs();
    set_slot(0, 0, 0, 3, 40, 1, 0);
    set_slot(1, 3, 0, 3, 41, 1, 0);
    #1;
    n_checks++; if (rs1_phy[11:6] !== 6'd40) $display("FAIL bypass_rs1: got %0d expected 40", rs1_phy[11:6]); else n_pass++;
    n_checks++; if (rd_phy_old[11:6] !== 6'd40) $display("FAIL bypass_old: got %0d expected 40", rd_phy_old[11:6]); else n_pass++;
    n_checks++; if (rd_phy_old[5:0] !== 6'd3) $display("FAIL bypass_old0: got %0d expected 3", rd_phy_old[5:0]); else n_pass++;
    tick();
    clear_inputs();
    #1;
    n_checks++; if (map_out[3*PHY_WIDTH +: PHY_WIDTH] !== 6'd41) $display("FAIL bypass_map: got %0d expected 41", map_out[3*PHY_WIDTH +: PHY_WIDTH]); else n_pass++;
  endtask

  task automatic test_ckpt_recover();
    clear_inputs();
    set_slot(0, 0, 0, 7, 50, 1, 1);
    set_slot(1, 0, 0, 7, 51, 1, 0);
    #1;
    n_checks++; if (ckpt_id !== '0) $display("FAIL ckpt_id0: got %0d expected 0", ckpt_id); else n_pass++;
    tick();
    clear_inputs();
    #1;
    n_checks++; if (map_out[7*PHY_WIDTH +: PHY_WIDTH] !== 6'd51) $display("FAIL ckpt_map_live: got %0d expected 51", map_out[7*PHY_WIDTH +: PHY_WIDTH]); else n_pass++;
    n_checks++; if (ckpt_count !== 3'd1) $display("FAIL ckpt_count1: got %0d expected 1", ckpt_count); else n_pass++;
    recover_valid = 1; recover_id = 0;
    #1;
    n_checks++; if (rn_ready !== 1'b0) $display("FAIL recover_stall: got %0d expected 0", rn_ready); else n_pass++;
    tick();
    clear_inputs();
    #1;
    n_checks++; if (map_out[7*PHY_WIDTH +: PHY_WIDTH] !== 6'd50) $display("FAIL recover_map: got %0d expected 50", map_out[7*PHY_WIDTH +: PHY_WIDTH]); else n_pass++;
    n_checks++; if (ckpt_count !== '0) $display("FAIL recover_count: got %0d expected 0", ckpt_count); else n_pass++;
  endtask

  task automatic test_full_release();
    do_reset();
    alloc_four();
    set_slot(0, 0, 0, 0, 0, 0, 1);
    #1;
    n_checks++; if (rn_ready !== 1'b0) $display("FAIL full_ready: got %0d expected 0", rn_ready); else n_pass++;
    n_checks++; if (ckpt_count !== 3'd4) $display("FAIL full_count: got %0d expected 4", ckpt_count); else n_pass++;
    tick();
    clear_inputs();
    #1;
    n_checks++; if (ckpt_count !== 3'd4) $display("FAIL full_hold: got %0d expected 4", ckpt_count); else n_pass++;
    ckpt_release_valid = 1; ckpt_release_id = 0;
    tick();
    clear_inputs();
    tick();
    set_slot(0, 0, 0, 0, 0, 0, 1);
    #1;
    n_checks++; if (ckpt_count !== 3'd3) $display("FAIL release_count: got %0d expected 3", ckpt_count); else n_pass++;
    n_checks++; if (rn_ready !== 1'b1) $display("FAIL release_ready: got %0d expected 1", rn_ready); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_recover_truncate();
    do_reset();
    alloc_four();
    ckpt_release_valid = 1; ckpt_release_id = 2;
    tick();
    clear_inputs();
    recover_valid = 1; recover_id = 1;
    tick();
    clear_inputs();
    #1;
    n_checks++; if (ckpt_count !== 3'd1) $display("FAIL trunc_count: got %0d expected 1", ckpt_count); else n_pass++;
    n_checks++; if (ckpt_id !== 2'd1) $display("FAIL trunc_tail: got %0d expected 1", ckpt_id); else n_pass++;
    ckpt_release_valid = 1; ckpt_release_id = 2;
    tick();
    clear_inputs();
    tick();
    #1;
    n_checks++; if (ckpt_count !== 3'd1) $display("FAIL stale_release: got %0d expected 1", ckpt_count); else n_pass++;
  endtask

  task automatic test_flush_recover();
    clear_inputs();
    set_slot(0, 0, 0, 5, 33, 1, 1);
    tick();
    for (int i = 0; i < ARCH_REGS; i++) back_rat[i*PHY_WIDTH +: PHY_WIDTH] = (i == 0) ? '0 : PHY_WIDTH'($urandom);
    clear_inputs();
    flush = 1; recover_valid = 1; recover_id = 0;
    #1;
    n_checks++; if (rn_ready !== 1'b0) $display("FAIL flush_ready: got %0d expected 0", rn_ready); else n_pass++;
    tick();
    clear_inputs();
    #1;
    n_checks++; if (map_out !== back_rat) $display("FAIL flush_map: got %h expected %h", map_out, back_rat); else n_pass++;
    n_checks++; if (ckpt_count !== '0) $display("FAIL flush_count: got %0d expected 0", ckpt_count); else n_pass++;
  endtask

  task automatic test_random();
    int sel;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      clear_inputs();
      rn_valid = RENAME_WIDTH'($urandom);
      rd_we = RENAME_WIDTH'($urandom);
      for (int k = 0; k < RENAME_WIDTH; k++) begin
        rs1_arch[k*AREG_W +: AREG_W] = AREG_W'($urandom_range(0, 7));
        rs2_arch[k*AREG_W +: AREG_W] = AREG_W'($urandom_range(0, 7));
        rd_arch[k*AREG_W +: AREG_W] = AREG_W'($urandom_range(0, 7));
        rd_phy_new[k*PHY_WIDTH +: PHY_WIDTH] = PHY_WIDTH'($urandom);
      end
      sel = $urandom_range(0, 3);
      ckpt_req = (sel < RENAME_WIDTH) ? RENAME_WIDTH'(1 << sel) : '0;
      ckpt_release_valid = ($urandom_range(0, 2) == 0);
      ckpt_release_id = CKPT_W'($urandom);
      recover_valid = ($urandom_range(0, 9) == 0);
      recover_id = CKPT_W'($urandom);
      flush = ($urandom_range(0, 59) == 0);
      if (flush) for (int i = 0; i < ARCH_REGS; i++) back_rat[i*PHY_WIDTH +: PHY_WIDTH] = PHY_WIDTH'($urandom);
      for (int i = 0; i < ARCH_REGS; i++) exp_map[i*PHY_WIDTH +: PHY_WIDTH] = PHY_WIDTH'(m_map[i]);
      #1;
      n_checks++; if (rn_ready !== m_ready()) $display("FAIL rnd_ready c%0d: got %0d expected %0d", c, rn_ready, m_ready()); else n_pass++;
      n_checks++; if (ckpt_id !== CKPT_W'(m_tail % N)) $display("FAIL rnd_ckpt_id c%0d: got %0d expected %0d", c, ckpt_id, m_tail % N); else n_pass++;
      n_checks++; if (ckpt_count !== (CKPT_W+1)'(m_count())) $display("FAIL rnd_count c%0d: got %0d expected %0d", c, ckpt_count, m_count()); else n_pass++;
      n_checks++; if (map_out !== exp_map) $display("FAIL rnd_map c%0d: got %h expected %h", c, map_out, exp_map); else n_pass++;
      for (int k = 0; k < RENAME_WIDTH; k++) begin
        n_checks++; if (rs1_phy[k*PHY_WIDTH +: PHY_WIDTH] !== PHY_WIDTH'(exp_lookup(k, int'(rs1_arch[k*AREG_W +: AREG_W]))))
          $display("FAIL rnd_rs1 c%0d s%0d: got %0d expected %0d", c, k, rs1_phy[k*PHY_WIDTH +: PHY_WIDTH], exp_lookup(k, int'(rs1_arch[k*AREG_W +: AREG_W]))); else n_pass++;
        n_checks++; if (rs2_phy[k*PHY_WIDTH +: PHY_WIDTH] !== PHY_WIDTH'(exp_lookup(k, int'(rs2_arch[k*AREG_W +: AREG_W]))))
          $display("FAIL rnd_rs2 c%0d s%0d: got %0d expected %0d", c, k, rs2_phy[k*PHY_WIDTH +: PHY_WIDTH], exp_lookup(k, int'(rs2_arch[k*AREG_W +: AREG_W]))); else n_pass++;
        n_checks++; if (rd_phy_old[k*PHY_WIDTH +: PHY_WIDTH] !== PHY_WIDTH'(exp_lookup(k, int'(rd_arch[k*AREG_W +: AREG_W]))))
          $display("FAIL rnd_old c%0d s%0d: got %0d expected %0d", c, k, rd_phy_old[k*PHY_WIDTH +: PHY_WIDTH], exp_lookup(k, int'(rd_arch[k*AREG_W +: AREG_W]))); else n_pass++;
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    set_slot(0, 0, 0, 9, 60, 1, 1);
    tick();
    clear_inputs();
    set_slot(1, 9, 0, 12, 61, 1, 0);
    #1;
    n_checks++; if (ckpt_count !== 3'd1) $display("FAIL pre_reset_count: got %0d expected 1", ckpt_count); else n_pass++;
    n_checks++; if (map_out[9*PHY_WIDTH +: PHY_WIDTH] !== 6'd60) $display("FAIL pre_reset_map: got %0d expected 60", map_out[9*PHY_WIDTH +: PHY_WIDTH]); else n_pass++;
    rst_n = 0;
    #1;
    n_checks++; if (map_out !== id_map) $display("FAIL async_reset_map: got %h expected %h", map_out, id_map); else n_pass++;
    n_checks++; if (ckpt_count !== '0) $display("FAIL async_reset_count: got %0d expected 0", ckpt_count); else n_pass++;
    clear_inputs();
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    for (int i = 0; i < ARCH_REGS; i++) id_map[i*PHY_WIDTH +: PHY_WIDTH] = PHY_WIDTH'(i);
    back_rat = '0;
    clear_inputs();
    test_reset();
    test_bypass();
    test_ckpt_recover();
    test_full_release();
    test_recover_truncate();
    test_flush_recover();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
